// File: rtl/alu_pkg.sv
// Shared types for the ALU issue front end.
// Op classes, result-mux selects and the write-back schedule entry.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD   = 2'd0,
    OP_BOOL  = 2'd1,
    OP_SHIFT = 2'd2,
    OP_RSVD  = 2'd3
  } op_class_e;

  localparam logic [2:0] EN_NONE  = 3'b000;
  localparam logic [2:0] EN_ADD   = 3'b001;
  localparam logic [2:0] EN_BOOL  = 3'b010;
  localparam logic [2:0] EN_SHIFT = 3'b100;

  localparam int DEF_SUB_W = 3;
  localparam int DEF_ID_W  = 4;

  typedef struct packed {
    logic                valid;
    logic [2:0]          unit;
    logic [DEF_ID_W-1:0] id;
  } sched_entry_t;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic [2:0] unit_of(op_class_e op);
    case (op)
      OP_ADD:   return EN_ADD;
      OP_BOOL:  return EN_BOOL;
      OP_SHIFT: return EN_SHIFT;
      default:  return EN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/alu_wb_sched.sv
// Result-bus reservation schedule: one slot per future cycle,
// slot 0 drives the result mux select this cycle.
module alu_wb_sched
  import alu_pkg::*;
#(
  parameter int ADD_LAT   = 2,
  parameter int BOOL_LAT  = 2,
  parameter int SHIFT_LAT = 4,
  parameter int ID_W      = DEF_ID_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            ins_valid_i,
  input  op_class_e       ins_op_i,
  input  logic [ID_W-1:0] ins_id_i,
  output logic            slot_free_o,
  output sched_entry_t    head_o
);

  localparam int MAX_LAT = max3(ADD_LAT, BOOL_LAT, SHIFT_LAT);

  sched_entry_t sched_q [MAX_LAT];
  sched_entry_t sched_d [MAX_LAT];
  sched_entry_t ins_ent;
  logic [MAX_LAT:0] free_from;
  int ins_lat;

  always_comb begin
    case (ins_op_i)
      OP_BOOL:  ins_lat = BOOL_LAT;
      OP_SHIFT: ins_lat = SHIFT_LAT;
      default:  ins_lat = ADD_LAT;
    endcase
  end

  // free_from[k]: no reservation at slot k or later
  always_comb begin
    free_from = '1;
    for (int k = 0; k < MAX_LAT; k++) begin
      for (int j = 0; j < MAX_LAT; j++) begin
        if (j >= k && sched_q[j].valid) begin
          free_from[k] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    slot_free_o = 1'b0;
    for (int k = 0; k <= MAX_LAT; k++) begin
      if (k == ins_lat) begin
        slot_free_o = free_from[k];
      end
    end
  end

  always_comb begin
    ins_ent       = '0;
    ins_ent.valid = 1'b1;
    ins_ent.unit  = unit_of(ins_op_i);
    ins_ent.id    = ins_id_i;
    for (int k = 0; k < MAX_LAT - 1; k++) begin
      sched_d[k] = sched_q[k+1];
    end
    sched_d[MAX_LAT-1] = '0;
    if (ins_valid_i) begin
      for (int k = 0; k < MAX_LAT; k++) begin
        if (k == ins_lat - 1) begin
          sched_d[k] = ins_ent;
        end
      end
    end
    if (flush_i) begin
      for (int k = 0; k < MAX_LAT; k++) begin
        sched_d[k] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MAX_LAT; k++) begin
        sched_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < MAX_LAT; k++) begin
        sched_q[k] <= sched_d[k];
      end
    end
  end

  assign head_o = sched_q[0];

endmodule

// File: rtl/alu_dispatch.sv
// ALU issue front end: handshake, unit strobes, operand bus,
// result-mux select and write-back tag stage.
module alu_dispatch
  import alu_pkg::*;
#(
  parameter int ADD_LAT   = 2,
  parameter int BOOL_LAT  = 2,
  parameter int SHIFT_LAT = 4,
  parameter int SUB_W     = DEF_SUB_W,
  parameter int ID_W      = DEF_ID_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  op_class_e        in_op,
  input  logic [SUB_W-1:0] in_sub,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [ID_W-1:0]  in_id,
  output logic             add_valid,
  output logic             bool_valid,
  output logic             shift_valid,
  output logic [31:0]      op_a,
  output logic [31:0]      op_b,
  output logic [SUB_W-1:0] op_sub,
  output logic [2:0]       en,
  output logic             wb_valid,
  output logic [ID_W-1:0]  wb_id
);

  logic         slot_free;
  logic         fire;
  sched_entry_t head;

  logic [2:0]       stb_q, stb_d;
  logic [31:0]      op_a_q, op_a_d;
  logic [31:0]      op_b_q, op_b_d;
  logic [SUB_W-1:0] op_sub_q, op_sub_d;
  logic             wb_valid_q, wb_valid_d;
  logic [ID_W-1:0]  wb_id_q, wb_id_d;

  alu_wb_sched #(
    .ADD_LAT   (ADD_LAT),
    .BOOL_LAT  (BOOL_LAT),
    .SHIFT_LAT (SHIFT_LAT),
    .ID_W      (ID_W)
  ) u_sched (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    .ins_valid_i (fire),
    .ins_op_i    (in_op),
    .ins_id_i    (in_id),
    .slot_free_o (slot_free),
    .head_o      (head)
  );

  assign in_ready = !flush && slot_free;
  assign fire     = in_valid && in_ready;

  always_comb begin
    stb_d      = fire ? unit_of(in_op) : EN_NONE;
    op_a_d     = fire ? in_a : op_a_q;
    op_b_d     = fire ? in_b : op_b_q;
    op_sub_d   = fire ? in_sub : op_sub_q;
    wb_valid_d = head.valid;
    wb_id_d    = head.id;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb_q      <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_sub_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_id_q    <= '0;
    end else begin
      stb_q      <= stb_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_sub_q   <= op_sub_d;
      wb_valid_q <= wb_valid_d;
      wb_id_q    <= wb_id_d;
    end
  end

  assign add_valid   = stb_q[0];
  assign bool_valid  = stb_q[1];
  assign shift_valid = stb_q[2];
  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign op_sub      = op_sub_q;
  assign en          = head.valid ? head.unit : EN_NONE;
  assign wb_valid    = wb_valid_q;
  assign wb_id       = wb_id_q;

endmodule
